// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer that shares the single-ported data memory
// between the CPU load/store path and the debug/loader port.
module dmem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16
) (
   input  logic              clk_pi,
   input  logic              reset_n_pi,
   input  logic              clk_en_pi,
   input  logic              cpu_req_pi,
   input  logic              cpu_we_pi,
   input  logic [ADDR_W-1:0] cpu_addr_pi,
   input  logic [DATA_W-1:0] cpu_wdata_pi,
   output logic              cpu_ack_po,
   output logic [DATA_W-1:0] cpu_rdata_po,
   output logic              cpu_rvalid_po,
   output logic              cpu_stall_po,
   input  logic              dbg_req_pi,
   input  logic              dbg_we_pi,
   input  logic [ADDR_W-1:0] dbg_addr_pi,
   input  logic [DATA_W-1:0] dbg_wdata_pi,
   output logic              dbg_ack_po,
   output logic [DATA_W-1:0] dbg_rdata_po,
   output logic              dbg_rvalid_po,
   output logic [ADDR_W-1:0] mem_addr_po,
   output logic [DATA_W-1:0] mem_wdata_po,
   output logic              mem_write_po,
   input  logic [DATA_W-1:0] mem_rdata_pi,
   output logic              busy_po
);

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_ACCESS = 1'b1;
   localparam logic       PORT_CPU  = 1'b0;
   localparam logic       PORT_DBG  = 1'b1;

   logic [0:0]        r_state;
   logic              r_prio;
   logic              r_win;
   logic              r_we;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_wdata;
   logic [DATA_W-1:0] r_cpu_rdata;
   logic [DATA_W-1:0] r_dbg_rdata;
   logic              r_cpu_rvalid;
   logic              r_dbg_rvalid;

   logic              w_access;
   logic              w_any_req;
   logic              w_pick_dbg;

   assign w_access   = (r_state == ST_ACCESS);
   assign w_any_req  = cpu_req_pi | dbg_req_pi;
   // dbg wins when it is the only requester, or on a tie when it holds priority
   assign w_pick_dbg = dbg_req_pi & (~cpu_req_pi | (r_prio == PORT_DBG));

   always_ff @(posedge clk_pi or negedge reset_n_pi) begin
      if (!reset_n_pi) begin
         r_state      <= ST_IDLE;
         r_prio       <= PORT_CPU;
         r_win        <= PORT_CPU;
         r_we         <= 1'b0;
         r_addr       <= '0;
         r_wdata      <= '0;
         r_cpu_rdata  <= '0;
         r_dbg_rdata  <= '0;
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
      end else if (clk_en_pi) begin
         r_cpu_rvalid <= 1'b0;
         r_dbg_rvalid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  r_state <= ST_ACCESS;
                  r_win   <= w_pick_dbg;
                  r_we    <= w_pick_dbg ? dbg_we_pi    : cpu_we_pi;
                  r_addr  <= w_pick_dbg ? dbg_addr_pi  : cpu_addr_pi;
                  r_wdata <= w_pick_dbg ? dbg_wdata_pi : cpu_wdata_pi;
               end
            end
            ST_ACCESS: begin
               // always return to IDLE so every grant is followed by a turnaround cycle
               r_state <= ST_IDLE;
               r_prio  <= ~r_win;
               if (!r_we) begin
                  if (r_win == PORT_DBG) begin
                     r_dbg_rdata  <= mem_rdata_pi;
                     r_dbg_rvalid <= 1'b1;
                  end else begin
                     r_cpu_rdata  <= mem_rdata_pi;
                     r_cpu_rvalid <= 1'b1;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy_po       = w_access;
   assign mem_write_po  = w_access & r_we;
   assign mem_addr_po   = r_addr;
   assign mem_wdata_po  = r_wdata;
   assign cpu_ack_po    = w_access & (r_win == PORT_CPU);
   assign dbg_ack_po    = w_access & (r_win == PORT_DBG);
   assign cpu_rdata_po  = r_cpu_rdata;
   assign dbg_rdata_po  = r_dbg_rdata;
   assign cpu_rvalid_po = r_cpu_rvalid;
   assign dbg_rvalid_po = r_dbg_rvalid;
   assign cpu_stall_po  = cpu_req_pi & ~cpu_ack_po;

endmodule
